bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one single-port block RAM (16-bit data, 256-deep, registered output, fixed read latency) between two requesters: requester 0 (compute FSM) and requester 1 (host/debug loader).
- Provides round-robin arbitration, an optional ownership lock for read-modify-write sequences, and a latency-matched read-return pipeline that tags each returned word with its requester ID.
- Sits between the requesters and the BRAM instance, and drives the BRAM's wea/addra/dina directly.

Parameters:
- DW, 16, data width.
- AW, 8, address width.
- RD_LAT, 2, BRAM read latency in cycles (legal range 1..4).

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request; held with its command until granted.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  AW  access address.
- wdata0, wdata1  in  DW  write data.
- lock0, lock1  in  1  keep ownership after this grant.
- gnt0, gnt1  out  1  one-cycle pulse: the command is issued to the BRAM this cycle.
- rvalid  out  1  read data valid.
- rid  out  1  requester that owns rdata.
- rdata  out  DW  read data (BRAM douta passed through).
- bram_we  out  1  to BRAM wea.
- bram_addr  out  AW  to BRAM addra.
- bram_din  out  DW  to BRAM dina.
- bram_dout  in  DW  from BRAM douta.

Behaviour:
- Reset (synchronous, active-high): state=S_IDLE, last=1 (so requester 0 wins the first tie), return pipeline cleared. gnt0, gnt1, rvalid, rid and bram_we are 0. bram_addr and bram_din are 0 while no grant is made.
- Grant is combinational from the current state and inputs. At most one grant per cycle, so there is at most one BRAM access per cycle. Back-to-back grants are allowed every cycle.
- Granted requester's command drives bram_we/bram_addr/bram_din in the same cycle. bram_we = we of the granted requester AND its gnt.
- Requesters must hold req, we, addr and wdata stable until gnt is seen. They drop req, or present the next command, in the cycle after gnt.
- State machine:
  - S_IDLE: only one req asserted -> grant it. Both asserted -> grant the one that is not last. If the granted requester has lock high at the grant -> go to S_OWN0 or S_OWN1.
  - S_OWNx: only requester x can be granted. The other requester's req is held off with gnt=0.
  - S_OWNx -> S_IDLE in the first cycle where lock_x=0. That cycle may itself carry a final grant to x.
- last register: updated to the granted ID on every grant.
- Read return: a RD_LAT-deep shift register of {valid, id}. A read grant at cycle T produces rvalid=1, rid=ID and rdata=bram_dout at cycle T+RD_LAT, for exactly 1 cycle. Writes produce no rvalid.
- Write then read to the same address on consecutive cycles: the read returns the newly written data, because the writes are ordered by issue. The arbiter performs no data forwarding.
- Reset mid-operation: in-flight reads are discarded, no rvalid appears after reset, and any lock is released.
- Invalid lock usage: lock asserted without req is ignored in S_IDLE.
- Starvation bound: in S_IDLE, a continuously requesting requester is granted within 2 cycles.

Optional Feature:
- Macro: BRAM_ARB_STATS_EN.
- With the macro defined:
  - Extra outputs gcnt0 and gcnt1 (16-bit): saturating grant counters per requester.
  - Extra output ccnt (16-bit): saturating count of cycles where a req was asserted but not granted.
  - Extra input stats_clr: synchronous clear of all three counters.
  - All counters reset to 0 and hold at 0xFFFF once reached.
- Without the macro: these ports and their logic do not exist, and the remaining behaviour is identical.

Test Plan:
- Single read: req0 read addr 0x05, BRAM holds 0x1234 at 0x05 -> gnt0 in cycle T; rvalid=1, rid=0, rdata=0x1234 at T+2 only.
- Contention after reset: req0 and req1 both held, both reads -> grant order 0,1,0,1 on consecutive cycles; four rvalid pulses with rid 0,1,0,1 at a 2-cycle offset.
- Lock: req0 with lock0=1 for 3 accesses while req1 is held -> gnt1 stays 0 until the cycle lock0 falls, then gnt1 on the next cycle.
- RMW ordering: req1 writes 0xBEEF to 0x80, then req1 reads 0x80 the next cycle -> rdata=0xBEEF with rid=1.
- Reset mid-flight: a read is granted, then rst pulses 1 cycle later -> no rvalid ever appears; after reset, req1 alone is granted immediately.
- Stats (macro on): 5 grants to 0, 3 to 1, 2 blocked cycles -> gcnt0=5, gcnt1=3, ccnt=2; stats_clr -> all 0 the next cycle.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter with ownership lock in front of a single-port BRAM,
// plus a latency-matched {valid,id} read-return pipeline. Optional grant/contention counters: BRAM_ARB_STATS_EN.
module bram_port_arbiter #(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid,
    output logic          rid,
    output logic [DW-1:0] rdata,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_din,
`ifdef BRAM_ARB_STATS_EN
    input  logic          stats_clr,
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1,
    output logic [15:0]   ccnt,
`endif
    input  logic [DW-1:0] bram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_id;
    logic              rd_issue;

    // State register and last-granted tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (gnt0)
                last <= 1'b0;
            else if (gnt1)
                last <= 1'b1;
        end
    end

    // Grant and next-state; grants are suppressed while reset is held
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        gnt0 = 1'b1;
                        if (lock0)
                            state_nxt = S_OWN0;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                        if (lock1)
                            state_nxt = S_OWN1;
                    end
                end
                S_OWN0: begin
                    gnt0 = req0;
                    if (!lock0)
                        state_nxt = S_IDLE;
                end
                S_OWN1: begin
                    gnt1 = req1;
                    if (!lock1)
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // BRAM command mux; address/data parked at zero when idle
    always_comb begin
        bram_we   = (gnt0 & we0) | (gnt1 & we1);
        bram_addr = '0;
        bram_din  = '0;
        if (gnt0) begin
            bram_addr = addr0;
            bram_din  = wdata0;
        end else if (gnt1) begin
            bram_addr = addr1;
            bram_din  = wdata1;
        end
    end

    assign rd_issue = (gnt0 & ~we0) | (gnt1 & ~we1);

    // Read-return tag pipeline, depth equals BRAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v[0]  <= rd_issue;
            pipe_id[0] <= gnt1;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    assign rvalid = pipe_v[RD_LAT-1];
    assign rid    = pipe_id[RD_LAT-1];
    assign rdata  = bram_dout;

`ifdef BRAM_ARB_STATS_EN
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CMAX = '1;

    logic blocked;
    assign blocked = (req0 & ~gnt0) | (req1 & ~gnt1);

    // Saturating grant and contention counters
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
            ccnt  <= '0;
        end else begin
            if (gnt0 && gcnt0 != CMAX)
                gcnt0 <= gcnt0 + CW'(1);
            if (gnt1 && gcnt1 != CMAX)
                gcnt1 <= gcnt1 + CW'(1);
            if (blocked && ccnt != CMAX)
                ccnt <= ccnt + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a 2-cycle-latency BRAM model.
// Stats checks are compiled in when BRAM_ARB_STATS_EN is defined.
module tb_bram_port_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid, rid, bram_we;
    logic [DW-1:0] rdata, bram_din, bram_dout;
    logic [AW-1:0] bram_addr;
`ifdef BRAM_ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   gcnt0, gcnt1, ccnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.DW(DW), .AW(AW), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
`ifdef BRAM_ARB_STATS_EN
        .stats_clr(stats_clr), .gcnt0(gcnt0), .gcnt1(gcnt1), .ccnt(ccnt),
`endif
        .bram_dout(bram_dout)
    );

    // BRAM model: registered output, two-cycle read latency, preload side port
    logic [DW-1:0] mem [256];
    logic [DW-1:0] d1, d2;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (bram_we)
            mem[bram_addr] <= bram_din;
        d1 <= mem[bram_addr];
        d2 <= d1;
    end
    assign bram_dout = d2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        req0 = 1; req1 = 1; addr0 = 8'h33; addr1 = 8'h44; we0 = 1; wdata0 = 16'h5555;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt: got gnt0=%b gnt1=%b, want 0 0", gnt0, gnt1);
        end
        n_checks++;
        if (rvalid !== 1'b0 || rid !== 1'b0 || bram_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_rvalid: got rvalid=%b rid=%b we=%b, want 0 0 0", rvalid, rid, bram_we);
        end
        n_checks++;
        if (bram_addr !== 8'h00 || bram_din !== 16'h0000) begin
            n_fail++; $display("FAIL reset_bus: got addr=%h din=%h, want 00 0000", bram_addr, bram_din);
        end
        tick();
        idle_inputs();
        rst = 0;
        // only req1 asserted after reset is granted at once
        req1 = 1; addr1 = 8'h20;
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || bram_addr !== 8'h20) begin
            n_fail++; $display("FAIL reset_first_req1: got gnt0=%b gnt1=%b addr=%h, want 0 1 20", gnt0, gnt1, bram_addr);
        end
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_single_read();
        do_reset();
        req0 = 1; addr0 = 8'h05;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || bram_we !== 1'b0 || bram_addr !== 8'h05) begin
            n_fail++; $display("FAIL single_grant: got gnt0=%b gnt1=%b we=%b addr=%h, want 1 0 0 05",
                               gnt0, gnt1, bram_we, bram_addr);
        end
        tick();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rvalid !== (k == 2)) begin
                n_fail++; $display("FAIL single_rvalid T+%0d: got %b, want %b", k, rvalid, (k == 2));
            end
            if (k == 2) begin
                n_checks++;
                if (rid !== 1'b0 || rdata !== 16'h1234) begin
                    n_fail++; $display("FAIL single_rdata: got rid=%b rdata=%h, want 0 1234", rid, rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        logic          eg0, ev, erid;
        logic [DW-1:0] ed;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req0 = (c < 4); addr0 = 8'h10;
            req1 = (c < 4); addr1 = 8'h20;
            eg0  = (c < 4) && (c % 2 == 0);
            ev   = (c >= 2);
            erid = (c % 2 == 1);
            ed   = erid ? 16'hB000 : 16'hA000;
            @(negedge clk);
            n_checks++;
            if (gnt0 !== eg0 || gnt1 !== ((c < 4) && !eg0)) begin
                n_fail++; $display("FAIL contention_gnt c%0d: got %b%b, want %b%b",
                                   c, gnt0, gnt1, eg0, ((c < 4) && !eg0));
            end
            n_checks++;
            if (rvalid !== ev || (ev && (rid !== erid || rdata !== ed))) begin
                n_fail++; $display("FAIL contention_ret c%0d: got v=%b id=%b d=%h, want v=%b id=%b d=%h",
                                   c, rvalid, rid, rdata, ev, erid, ed);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        logic [4:0] eg0 = 5'b00111;
        logic [4:0] eg1 = 5'b10000;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req0 = (c < 3); lock0 = (c < 3); addr0 = 8'h10;
            req1 = 1;       addr1 = 8'h20;
            @(negedge clk);
            n_checks++;
            if (gnt0 !== eg0[c] || gnt1 !== eg1[c]) begin
                n_fail++; $display("FAIL lock_gnt c%0d: got %b%b, want %b%b", c, gnt0, gnt1, eg0[c], eg1[c]);
            end
            tick();
        end
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_back_to_back_rmw();
        do_reset();
        req1 = 1; we1 = 1; addr1 = 8'h80; wdata1 = 16'hBEEF;
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 8'h80 || bram_din !== 16'hBEEF) begin
            n_fail++; $display("FAIL rmw_write: got gnt1=%b we=%b addr=%h din=%h, want 1 1 80 beef",
                               gnt1, bram_we, bram_addr, bram_din);
        end
        tick();
        we1 = 0; wdata1 = '0;
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1 || bram_we !== 1'b0 || bram_addr !== 8'h80) begin
            n_fail++; $display("FAIL rmw_read: got gnt1=%b we=%b addr=%h, want 1 0 80", gnt1, bram_we, bram_addr);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rmw_write_no_rvalid: got %b, want 0", rvalid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rid !== 1'b1 || rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL rmw_return: got v=%b id=%b d=%h, want 1 1 beef", rvalid, rid, rdata);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req0 = 1; lock0 = 1; addr0 = 8'h05;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL midrst_grant: got gnt0=%b, want 1", gnt0);
        end
        tick();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_rvalid_in_rst: got %b, want 0", rvalid);
        end
        tick();
        rst = 0;
        req1 = 1; addr1 = 8'h20;
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_after: got gnt0=%b gnt1=%b rvalid=%b, want 0 1 0", gnt0, gnt1, rvalid);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_stale: got %b, want 0", rvalid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rid !== 1'b1 || rdata !== 16'hB000) begin
            n_fail++; $display("FAIL midrst_req1_return: got v=%b id=%b d=%h, want 1 1 b000", rvalid, rid, rdata);
        end
        tick();
    endtask

`ifdef BRAM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req0 = (c < 6); addr0 = 8'h10;
            req1 = (c < 2) || (c >= 6); addr1 = 8'h20;
            tick();
        end
        idle_inputs();
        stats_clr = 1;
        @(negedge clk);
        n_checks++;
        if (gcnt0 !== 16'd5 || gcnt1 !== 16'd3 || ccnt !== 16'd2) begin
            n_fail++; $display("FAIL stats_counts: got %0d %0d %0d, want 5 3 2", gcnt0, gcnt1, ccnt);
        end
        tick();
        stats_clr = 0;
        @(negedge clk);
        n_checks++;
        if (gcnt0 !== 16'd0 || gcnt1 !== 16'd0 || ccnt !== 16'd0) begin
            n_fail++; $display("FAIL stats_clear: got %0d %0d %0d, want 0 0 0", gcnt0, gcnt1, ccnt);
        end
        tick();
    endtask
`endif

    initial begin
        rst = 1;
        pre_we = 0; pre_addr = '0; pre_data = '0;
`ifdef BRAM_ARB_STATS_EN
        stats_clr = 0;
`endif
        idle_inputs();
        tick();
        preload(8'h05, 16'h1234);
        preload(8'h10, 16'hA000);
        preload(8'h20, 16'hB000);
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_back_to_back_rmw();
        test_reset_midflight();
`ifdef BRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
